// File: rtl/uart_pkg.sv
// Shared types and constants for the loopback UART demo: baud divisors,
// TX/RX state encodings and active-low 7-segment glyphs.
package uart_pkg;

  localparam int DIV_W = 14;

  localparam int unsigned BAUD_RATES [8] = '{
    300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
  };

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Segment order {a,b,c,d,e,f,g}, low = lit; b and d are lower case.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Clocks per 16x oversample tick, rounded to nearest.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                 input int unsigned idx);
    int unsigned den;
    den = 16 * BAUD_RATES[idx];
    return DIV_W'((clk_hz + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_controller.sv
// 16x oversample tick generator shared by TX and RX; restarts whenever the
// selected rate changes.
module uart_baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_en
);

  logic [DIV_W-1:0] div_table [8];
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       sel_reg;
  logic             sample_en_reg, sample_en_next;

  for (genvar gi = 0; gi < 8; gi++) begin : g_div
    assign div_table[gi] = baud_div(CLK_HZ, gi);
  end

  always_comb begin
    cnt_next       = cnt_reg + 1'b1;
    sample_en_next = 1'b0;
    if (baud_select != sel_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == div_table[sel_reg] - 1'b1) begin
      cnt_next       = '0;
      sample_en_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= '0;
      sel_reg       <= '0;
      sample_en_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      sel_reg       <= baud_select;
      sample_en_reg <= sample_en_next;
    end
  end

  assign sample_en = sample_en_reg;

endmodule

// File: rtl/uart_led.sv
// UART TX and RX in internal loopback; received bytes scroll onto a
// 4-digit multiplexed 7-segment display, dashes on a framing/parity error.
module uart_led
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int          REFRESH_BITS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic [7:0] Tx_DATA,
  input  logic       Tx_WR,
  input  logic       Tx_EN,
  input  logic       Rx_EN,
  output logic       Tx_BUSY,
  output logic [3:0] anode,
  output logic [6:0] LEDOutput
);

  logic sample_en;
  logic tx_line;
  logic loop_line;

  uart_baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
    .clock       (clock),
    .reset       (reset),
    .baud_select (baud_select),
    .sample_en   (sample_en)
  );

  assign loop_line = tx_line;

  // ---------------- transmitter ----------------
  tx_state_t  tx_state_reg, tx_state_next;
  logic [3:0] tx_tick_reg, tx_tick_next;
  logic [2:0] tx_bit_reg, tx_bit_next;
  logic [7:0] tx_data_reg, tx_data_next;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_tick_next  = tx_tick_reg;
    tx_bit_next   = tx_bit_reg;
    tx_data_next  = tx_data_reg;
    if (!Tx_EN) begin
      tx_state_next = TX_IDLE;
    end else if (tx_state_reg == TX_IDLE) begin
      if (Tx_WR) begin
        tx_state_next = TX_START;
        tx_data_next  = Tx_DATA;
        tx_tick_next  = '0;
        tx_bit_next   = '0;
      end
    end else if (sample_en) begin
      tx_tick_next = tx_tick_reg + 1'b1;
      if (tx_tick_reg == 4'd15) begin
        case (tx_state_reg)
          TX_START:  tx_state_next = TX_DATA;
          TX_DATA: begin
            if (tx_bit_reg == 3'd7) tx_state_next = TX_PARITY;
            else                    tx_bit_next   = tx_bit_reg + 1'b1;
          end
          TX_PARITY: tx_state_next = TX_STOP;
          default:   tx_state_next = TX_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (tx_state_reg)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_data_reg[tx_bit_reg];
      TX_PARITY: tx_line = ^tx_data_reg;
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_reg <= TX_IDLE;
      tx_tick_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_data_reg  <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_tick_reg  <= tx_tick_next;
      tx_bit_reg   <= tx_bit_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  assign Tx_BUSY = (tx_state_reg != TX_IDLE);

  // ---------------- receiver ----------------
  rx_state_t   rx_state_reg, rx_state_next;
  logic [3:0]  rx_tick_reg, rx_tick_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_par_reg, rx_par_next;
  logic        rx_prev_reg;
  logic [15:0] disp_reg, disp_next;
  logic        err_reg, err_next;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_tick_next  = rx_tick_reg;
    rx_bit_next   = rx_bit_reg;
    rx_data_next  = rx_data_reg;
    rx_par_next   = rx_par_reg;
    disp_next     = disp_reg;
    err_next      = err_reg;
    if (!Rx_EN) begin
      rx_state_next = RX_IDLE;
    end else if (rx_state_reg == RX_IDLE) begin
      if (rx_prev_reg && !loop_line) begin
        rx_state_next = RX_START;
        rx_tick_next  = '0;
        rx_bit_next   = '0;
      end
    end else if (sample_en) begin
      rx_tick_next = rx_tick_reg + 1'b1;
      // Tick 8 is mid-bit: sample; tick 16 closes the bit.
      if (rx_tick_reg == 4'd7) begin
        case (rx_state_reg)
          RX_START:  if (loop_line) rx_state_next = RX_IDLE;
          RX_DATA:   rx_data_next = {loop_line, rx_data_reg[7:1]};
          RX_PARITY: rx_par_next = loop_line;
          RX_STOP: begin
            rx_state_next = RX_IDLE;
            if (loop_line && (rx_par_reg == ^rx_data_reg)) begin
              disp_next = {disp_reg[7:0], rx_data_reg};
              err_next  = 1'b0;
            end else begin
              err_next  = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (rx_tick_reg == 4'd15) begin
        case (rx_state_reg)
          RX_START:  rx_state_next = RX_DATA;
          RX_DATA: begin
            if (rx_bit_reg == 3'd7) rx_state_next = RX_PARITY;
            else                    rx_bit_next   = rx_bit_reg + 1'b1;
          end
          RX_PARITY: rx_state_next = RX_STOP;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_reg <= RX_IDLE;
      rx_tick_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_data_reg  <= '0;
      rx_par_reg   <= 1'b0;
      rx_prev_reg  <= 1'b1;
      disp_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_tick_reg  <= rx_tick_next;
      rx_bit_reg   <= rx_bit_next;
      rx_data_reg  <= rx_data_next;
      rx_par_reg   <= rx_par_next;
      rx_prev_reg  <= loop_line;
      disp_reg     <= disp_next;
      err_reg      <= err_next;
    end
  end

  // ---------------- display scanner ----------------
  logic [REFRESH_BITS-1:0] scan_reg;
  logic [1:0]              digit;
  logic [3:0]              nibble;
  logic [3:0]              anode_reg, anode_next;
  logic [6:0]              seg_reg, seg_next;

  assign digit  = scan_reg[REFRESH_BITS-1 -: 2];
  assign nibble = disp_reg[{digit, 2'b00} +: 4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_anode
    assign anode_next[gi] = (digit != 2'(gi));
  end

  assign seg_next = err_reg ? SEG_DASH : HEX_SEG[nibble];

  // Outputs are registered so reset blanks the display immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_reg  <= '0;
      anode_reg <= 4'b1111;
      seg_reg   <= SEG_OFF;
    end else begin
      scan_reg  <= scan_reg + 1'b1;
      anode_reg <= anode_next;
      seg_reg   <= seg_next;
    end
  end

  assign anode     = anode_reg;
  assign LEDOutput = seg_reg;

endmodule

// File: tb/tb_uart_led.sv
// Loopback bench: bytes are written to TX, expected display contents are
// queued at write time and compared against the scanned 7-segment outputs.
module tb_uart_led;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = 3'd7;
  logic [7:0] Tx_DATA = 8'h00;
  logic       Tx_WR = 1'b0;
  logic       Tx_EN = 1'b1;
  logic       Rx_EN = 1'b1;
  logic       Tx_BUSY;
  logic [3:0] anode;
  logic [6:0] LEDOutput;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        err;
    logic [15:0] disp;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_disp = 16'h0000;
  logic        model_err  = 1'b0;

  uart_led #(.CLK_HZ(50_000_000), .REFRESH_BITS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_DATA     (Tx_DATA),
    .Tx_WR       (Tx_WR),
    .Tx_EN       (Tx_EN),
    .Rx_EN       (Rx_EN),
    .Tx_BUSY     (Tx_BUSY),
    .anode       (anode),
    .LEDOutput   (LEDOutput)
  );

  always #10 clock = ~clock;

  // Glyphs written active-high {a..g}, inverted for the active-low pins.
  function automatic logic [6:0] glyph(input logic [3:0] n, input logic err);
    logic [6:0] hi;
    case (n)
      4'h0: hi = 7'b1111110;  4'h1: hi = 7'b0110000;
      4'h2: hi = 7'b1101101;  4'h3: hi = 7'b1111001;
      4'h4: hi = 7'b0110011;  4'h5: hi = 7'b1011011;
      4'h6: hi = 7'b1011111;  4'h7: hi = 7'b1110000;
      4'h8: hi = 7'b1111111;  4'h9: hi = 7'b1111011;
      4'hA: hi = 7'b1110111;  4'hB: hi = 7'b0011111;
      4'hC: hi = 7'b1001110;  4'hD: hi = 7'b0111101;
      4'hE: hi = 7'b1001111;  default: hi = 7'b1000111;
    endcase
    if (err) hi = 7'b0000001;
    return ~hi;
  endfunction

  task automatic check_value(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.err  = model_err;
    e.disp = model_disp;
    exp_q.push_back(e);
  endtask

  task automatic check_display(input string tag);
    exp_t       e;
    int         n;
    logic [3:0] want_an;
    if (exp_q.size() == 0) begin
      check_value({tag, "_queue"}, 16'd0, 16'd1);
      return;
    end
    e = exp_q.pop_front();
    for (int d = 0; d < 4; d++) begin
      want_an = ~(4'b0001 << d);
      n = 0;
      while (anode !== want_an && n < 2048) begin
        @(posedge clock); #1; n++;
      end
      check_value($sformatf("%s_anode%0d", tag, d), 16'(anode), 16'(want_an));
      check_value($sformatf("%s_seg%0d", tag, d), 16'(LEDOutput),
                  16'(glyph(e.disp[4*d +: 4], e.err)));
    end
    $display("display %s: expected disp=%h err=%b", tag, e.disp, e.err);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] data,
                           input logic corrupt, input logic inject_mid);
    int n;
    int dur;
    @(negedge clock); Tx_DATA = data; Tx_WR = 1'b1;
    @(negedge clock); Tx_WR = 1'b0;
    if (corrupt) model_err = 1'b1;
    else begin
      model_disp = {model_disp[7:0], data};
      model_err  = 1'b0;
    end
    push_expected();
    n = 0;
    while (!Tx_BUSY && n < 100) begin @(negedge clock); n++; end
    check_value({tag, "_busy_rise"}, 16'(Tx_BUSY), 16'd1);
    dur = 0;
    while (Tx_BUSY && dur < 6000) begin
      @(negedge clock); dur++;
      if (inject_mid && dur == 1000) begin Tx_DATA = 8'h55; Tx_WR = 1'b1; end
      if (inject_mid && dur == 1001) Tx_WR = 1'b0;
      if (corrupt && dur == 3950) force dut.loop_line = 1'b1;
      if (corrupt && dur == 4250) release dut.loop_line;
    end
    check_value({tag, "_busy_len_ok"}, 16'(dur >= 4650 && dur <= 4780), 16'd1);
    $display("tx %s: data=%h corrupt=%b busy_cycles=%0d", tag, data, corrupt, dur);
    repeat (20) @(negedge clock);
    check_display(tag);
  endtask

  task automatic measure_tick(input string tag, input logic [2:0] sel,
                              input logic [15:0] want);
    int n;
    int period;
    @(negedge clock); baud_select = sel;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!dut.sample_en && n < 12000);
    period = 0;
    do begin @(posedge clock); #1; period++; end while (!dut.sample_en && period < 12000);
    check_value(tag, 16'(period), want);
    $display("tick %s: sel=%0d period=%0d", tag, sel, period);
  endtask

  initial begin
    int  n;
    logic busy_seen;
    logic line_low_seen;

    #5 reset = 1'b0;
    #20;
    check_value("rst_busy", 16'(Tx_BUSY), 16'd0);
    check_value("rst_anode", 16'(anode), 16'hF);
    check_value("rst_seg", 16'(LEDOutput), 16'h7F);
    check_value("rst_line", 16'(dut.loop_line), 16'd1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_disp = 16'h0000; model_err = 1'b0;
    push_expected();
    check_display("post_reset");

    send_byte("a8", 8'hA8, 1'b0, 1'b0);
    send_byte("17_with_55_mid", 8'h17, 1'b0, 1'b1);

    // Tx_EN low: the write must be dropped entirely.
    @(negedge clock); Tx_EN = 1'b0; Tx_DATA = 8'h99; Tx_WR = 1'b1;
    @(negedge clock); Tx_WR = 1'b0;
    push_expected();
    busy_seen = 1'b0; line_low_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (Tx_BUSY) busy_seen = 1'b1;
      if (!dut.loop_line) line_low_seen = 1'b1;
    end
    check_value("txen0_busy", 16'(busy_seen), 16'd0);
    check_value("txen0_line_low", 16'(line_low_seen), 16'd0);
    $display("tx txen0: write of 99 with Tx_EN=0");
    check_display("txen0");
    Tx_EN = 1'b1;

    send_byte("81_bad_parity", 8'h81, 1'b1, 1'b0);
    send_byte("3c", 8'h3C, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    @(negedge clock); Tx_DATA = 8'h42; Tx_WR = 1'b1;
    @(negedge clock); Tx_WR = 1'b0;
    repeat (2000) @(negedge clock);
    reset = 1'b0;
    #1;
    check_value("midrst_busy", 16'(Tx_BUSY), 16'd0);
    check_value("midrst_anode", 16'(anode), 16'hF);
    check_value("midrst_seg", 16'(LEDOutput), 16'h7F);
    $display("reset mid-frame of 42");
    repeat (5) @(negedge clock);
    reset = 1'b1;
    model_disp = 16'h0000; model_err = 1'b0;
    push_expected();
    n = 0;
    repeat (5000) begin @(negedge clock); if (Tx_BUSY) n++; end
    check_value("midrst_no_busy", 16'(n), 16'd0);
    check_display("after_midrst");

    measure_tick("tick_sel0", 3'd0, 16'd10417);
    measure_tick("tick_sel3", 3'd3, 16'd326);
    measure_tick("tick_sel7", 3'd7, 16'd27);

    check_value("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
